// File: rtl/de0_baseline_pkg.sv
// Shared constants for the DE0-Nano-SoC push-button counter baseline.
package de0_baseline_pkg;

    // Bit positions of the two push-buttons inside the keys bus
    localparam int unsigned KEY_CLR = 0;
    localparam int unsigned KEY_INC = 1;

    // Default build parameters
    localparam int unsigned DEF_WIDTH           = 8;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 2;

endpackage : de0_baseline_pkg

// File: rtl/key_conditioner.sv
// Conditions one asynchronous push-button: synchronizer, debounce filter
// and rising-edge detector producing a single-cycle press pulse.
module key_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic [CW-1:0]          stable_cnt;
    logic                   level_d;

    assign synced = sync[SYNC_STAGES-1];

    // Multi-flop synchronizer; sync[0] is the metastability-capture stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], key_in};
        end
    end

    // Accept a new level only after it has differed from the accepted one
    // for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the run
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (synced == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level      <= synced;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CW'(1);
        end
    end

    // Remember the previous accepted level for press-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // Pulse only on an accepted press; releases produce nothing
    assign rise = level & ~level_d;

endmodule : key_conditioner

// File: rtl/de0_nano_soc_baseline.sv
// Board baseline: counts debounced push-button presses and shows the
// count on the LEDs. keys[0] clears, keys[1] increments; clear has priority.
module de0_nano_soc_baseline
    import de0_baseline_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       keys,
    output logic [WIDTH-1:0] leds
);

    // Accepted key levels are not needed by the counter, only the press pulses
    logic [1:0]       levels_unused;
    logic [1:0]       rise;
    logic [WIDTH-1:0] count;

    key_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_clr (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (keys[KEY_CLR]),
        .level  (levels_unused[KEY_CLR]),
        .rise   (rise[KEY_CLR])
    );

    key_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_inc (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (keys[KEY_INC]),
        .level  (levels_unused[KEY_INC]),
        .rise   (rise[KEY_INC])
    );

    // Press counter: clear beats increment, increment wraps modulo 2^WIDTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (rise[KEY_CLR]) begin
            count <= '0;
        end else if (rise[KEY_INC]) begin
            count <= count + WIDTH'(1);
        end
    end

    assign leds = count;

endmodule : de0_nano_soc_baseline

// File: tb/tb_de0_nano_soc_baseline.sv
// Self-checking bench for de0_nano_soc_baseline: directed scenarios plus
// randomized key activity against a sample-window reference model.
module tb_de0_nano_soc_baseline;
    import de0_baseline_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;
    localparam int unsigned D = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   keys  = 2'b00;
    logic [W-1:0] leds;

    de0_nano_soc_baseline #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .keys  (keys),
        .leds  (leds)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: remembers raw key samples per edge. A key's accepted
    // level flips when the last D samples the filter has seen (delayed by S
    // edges) all disagree with it; a 0->1 flip is a press acted on next edge.
    bit          hist [2][S+D];
    bit          m_level [2];
    bit          m_press [2];
    int unsigned m_count = 0;
    bit          model_live = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < S + D; i++) hist[k][i] = 1'b0;
                m_level[k] = 1'b0;
                m_press[k] = 1'b0;
            end
            m_count    = 0;
            model_live = 1'b1;
        end else begin
            if (m_press[KEY_CLR])      m_count = 0;
            else if (m_press[KEY_INC]) m_count = (m_count + 1) % (1 << W);
            for (int k = 0; k < 2; k++) begin
                bit flip;
                for (int i = S + D - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = keys[k];
                flip = 1'b1;
                for (int i = S; i < S + D; i++)
                    if (hist[k][i] == m_level[k]) flip = 1'b0;
                m_press[k] = flip && !m_level[k];
                if (flip) m_level[k] = !m_level[k];
            end
        end
    end

    // Every cycle the LEDs must match the model
    always @(negedge clk) begin
        if (model_live) check_eq("leds_vs_model", {24'd0, leds}, m_count);
    end

    task automatic press(input int unsigned idx, input int unsigned hi, input int unsigned lo);
        keys[idx] = 1'b1;
        repeat (hi) @(negedge clk);
        keys[idx] = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Increment press with exact latency check: update appears after edge k+4
    task automatic press_inc_latency(input int unsigned exp_after);
        keys[KEY_INC] = 1'b1;
        repeat (3) @(negedge clk);
        keys[KEY_INC] = 1'b0;
        @(negedge clk);
        check_eq("latency_before", {24'd0, leds}, exp_after - 1);
        @(negedge clk);
        check_eq("latency_update", {24'd0, leds}, exp_after);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Reset with both keys held, then release: clear and increment coincide
        rst_n = 1'b0;
        keys  = 2'b11;
        repeat (3) @(negedge clk);
        check_eq("reset_hold", {24'd0, leds}, 0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("reset_clear_wins", {24'd0, leds}, 0);
        keys = 2'b00;
        repeat (8) @(negedge clk);

        // Counting with latency checks
        press_inc_latency(1);
        press_inc_latency(2);
        check_eq("count_two", {24'd0, leds}, 2);

        // Clear then count
        press(KEY_CLR, 3, 6);
        check_eq("clear_after_two", {24'd0, leds}, 0);
        repeat (3) press(KEY_INC, 3, 6);
        check_eq("count_three", {24'd0, leds}, 3);
        press(KEY_CLR, 3, 6);
        check_eq("clear_after_three", {24'd0, leds}, 0);

        // Glitch rejection
        press(KEY_INC, 1, 10);
        check_eq("glitch_high", {24'd0, leds}, 0);
        keys[KEY_INC] = 1'b1;
        repeat (8) @(negedge clk);
        keys[KEY_INC] = 1'b0;
        @(negedge clk);
        keys[KEY_INC] = 1'b1;
        repeat (8) @(negedge clk);
        keys[KEY_INC] = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("dip_no_double", {24'd0, leds}, 1);
        press(KEY_CLR, 3, 6);

        // Wrap-around
        for (int i = 0; i < 256; i++) begin
            press(KEY_INC, 3, 3);
            if (i == 254) check_eq("wrap_reach_255", {24'd0, leds}, 255);
        end
        check_eq("wrap_to_zero", {24'd0, leds}, 0);
        press(KEY_INC, 50, 8);
        check_eq("long_hold_once", {24'd0, leds}, 1);

        // Reset in the middle of a debounce run
        press(KEY_CLR, 3, 6);
        repeat (5) press(KEY_INC, 3, 6);
        check_eq("midop_five", {24'd0, leds}, 5);
        keys[KEY_INC] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midop_reset", {24'd0, leds}, 0);
        keys = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("no_inc_after_reset", {24'd0, leds}, 0);

        // Randomized key activity with occasional resets
        for (int seg = 0; seg < 500; seg++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) keys[KEY_CLR] = 1'($urandom);
            keys[KEY_INC] = 1'($urandom);
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        keys = 2'b00;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_de0_nano_soc_baseline
